// File: rtl/retire_store_ctrl_pkg.sv
// Shared types for the retire-time store sequencer: store size, FSM state, block width.
package retire_store_ctrl_pkg;

  localparam int unsigned BLOCK_W   = 64;
  localparam int unsigned BLK_OFS_W = 3;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } rsc_state_e;

endpackage

// File: rtl/retire_store_ctrl_lane_merge.sv
// Combinational merge of a store into a 64-bit block, plus the alignment check.
module store_lane_merge
  import retire_store_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [BLOCK_W-1:0]   blk_in,
  input  logic [BLK_OFS_W-1:0] addr,
  input  logic [XLEN-1:0]      data,
  input  mem_size_e            size,
  output logic [BLOCK_W-1:0]   blk_out,
  output logic                 misalign
);

  // DOUBLE stores only carry XLEN bits, so they land in the same lane as WORD.
  always_comb begin
    blk_out  = blk_in;
    misalign = 1'b0;
    case (size)
      BYTE: blk_out[{addr, 3'b000} +: 8] = data[7:0];
      HALF: begin
        misalign = addr[0];
        blk_out[{addr[2:1], 4'b0000} +: 16] = data[15:0];
      end
      default: begin
        misalign = |addr[1:0];
        blk_out[{addr[2], 5'b00000} +: 32] = data[31:0];
      end
    endcase
  end

endmodule

// File: rtl/retire_store_ctrl.sv
// Retire-time store sequencer: read-modify-write of one 64-bit dcache block per store.
// Optional RETIRE_STORE_FWD_EN keeps the last written block to skip the read on a same-block store.
module retire_store_ctrl
  import retire_store_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               st_req,
  input  logic [XLEN-1:0]    st_addr,
  input  logic [XLEN-1:0]    st_data,
  input  logic [1:0]         st_size,
  output logic               st_ack,
  output logic               st_misalign,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_gnt,
  input  logic               rd_valid,
  input  logic [BLOCK_W-1:0] rd_data,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [BLOCK_W-1:0] wr_data,
  input  logic               wr_gnt,
  output logic               busy
);

  localparam int unsigned TAG_W = XLEN - BLK_OFS_W;

  rsc_state_e         state, state_nx;
  logic [XLEN-1:0]    addr_q, data_q;
  mem_size_e          size_q;
  logic [BLOCK_W-1:0] blk_q;
  logic               mis_q;

  logic               in_idle;
  logic [XLEN-1:0]    m_addr, m_data;
  mem_size_e          m_size;
  logic [BLOCK_W-1:0] merge_base, merged;
  logic               mis_c, hit_c;
  logic [ADDR_W-1:0]  blk_addr;

  assign in_idle  = (state == IDLE);
  assign m_addr   = in_idle ? st_addr : addr_q;
  assign m_data   = in_idle ? st_data : data_q;
  assign m_size   = in_idle ? mem_size_e'(st_size) : size_q;
  assign blk_addr = ADDR_W'({addr_q[XLEN-1:BLK_OFS_W], 3'b000});

`ifdef RETIRE_STORE_FWD_EN
  logic               fwd_valid;
  logic [TAG_W-1:0]   fwd_tag;
  logic [BLOCK_W-1:0] fwd_blk;

  // Our own granted write replaces the kept copy, which also drops any other block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_tag   <= '0;
      fwd_blk   <= '0;
    end else if (state == WR_REQ && wr_gnt) begin
      fwd_valid <= 1'b1;
      fwd_tag   <= addr_q[XLEN-1:BLK_OFS_W];
      fwd_blk   <= blk_q;
    end
  end

  assign hit_c      = fwd_valid && (st_addr[XLEN-1:BLK_OFS_W] == fwd_tag);
  assign merge_base = in_idle ? fwd_blk : rd_data;
`else
  assign hit_c      = 1'b0;
  assign merge_base = rd_data;
`endif

  store_lane_merge #(.XLEN(XLEN)) u_merge (
    .blk_in   (merge_base),
    .addr     (m_addr[BLK_OFS_W-1:0]),
    .data     (m_data),
    .size     (m_size),
    .blk_out  (merged),
    .misalign (mis_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (st_req) begin
          if (mis_c)      state_nx = DONE;
          else if (hit_c) state_nx = WR_REQ;
          else            state_nx = RD_REQ;
        end
      end
      RD_REQ:  if (rd_gnt) state_nx = rd_valid ? WR_REQ : RD_WAIT;
      RD_WAIT: if (rd_valid) state_nx = WR_REQ;
      WR_REQ:  if (wr_gnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Store latch and merged block; the block is captured on the cycle read data arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= BYTE;
      blk_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st_req) begin
            addr_q <= st_addr;
            data_q <= st_data;
            size_q <= m_size;
            mis_q  <= mis_c;
            if (hit_c && !mis_c) blk_q <= merged;
          end
        end
        RD_REQ:  if (rd_gnt && rd_valid) blk_q <= merged;
        RD_WAIT: if (rd_valid) blk_q <= merged;
        default: ;
      endcase
    end
  end

  always_comb begin
    st_ack      = 1'b0;
    st_misalign = 1'b0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    wr_req      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    busy        = !in_idle;
    case (state)
      RD_REQ: begin
        rd_req  = 1'b1;
        rd_addr = blk_addr;
      end
      WR_REQ: begin
        wr_req  = 1'b1;
        wr_addr = blk_addr;
        wr_data = blk_q;
      end
      DONE: begin
        st_ack      = 1'b1;
        st_misalign = mis_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_retire_store_ctrl.sv
// Bench for retire_store_ctrl: directed cases then random stores against a byte-level model.
module tb_retire_store_ctrl;

  logic        clock, reset;
  logic        st_req;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        st_ack, st_misalign;
  logic        rd_req, rd_gnt, rd_valid;
  logic [63:0] rd_addr, rd_data;
  logic        wr_req, wr_gnt;
  logic [63:0] wr_addr, wr_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the kept block; only ever set when forwarding is built in.
  bit          m_fwd_valid = 1'b0;
  logic [28:0] m_fwd_tag   = '0;
  logic [63:0] m_fwd_blk   = '0;

  logic [63:0] wd;

  retire_store_ctrl dut (
    .clock(clock), .reset(reset),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ack(st_ack), .st_misalign(st_misalign),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_misalign(input logic [31:0] a, input logic [1:0] sz);
    return (a % size_bytes(sz)) != 0;
  endfunction

  function automatic logic [63:0] model_merge(input logic [63:0] base, input logic [31:0] a,
                                              input logic [31:0] d, input logic [1:0] sz);
    logic [63:0] r;
    int n, start;
    r = base;
    n = size_bytes(sz);
    start = ((a % 8) / n) * n;
    for (int i = 0; i < n; i++) r[(start + i) * 8 +: 8] = d[i * 8 +: 8];
    return r;
  endfunction

  // One store with a scripted dcache: rd_gnt after rg waits, rd_valid rv cycles after grant,
  // wr_gnt after wg waits. drop releases st_req once the controller has taken it.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic [63:0] rdat, input int rg, input int rv, input int wg,
                          input bit drop, output logic [63:0] wd_seen);
    logic [63:0] exp_wd, exp_blk;
    bit mis, hit, saw_rd, saw_wr, done, rd_wait;
    int cyc, rd_cnt, wr_cnt, rd_k, exp_lat;
    mis     = model_misalign(a, sz);
    hit     = !mis && m_fwd_valid && (a[31:3] == m_fwd_tag);
    exp_wd  = model_merge(hit ? m_fwd_blk : rdat, a, d, sz);
    exp_blk = {32'd0, a[31:3], 3'b000};
    exp_lat = mis ? 1 : hit ? wg + 2 : rg + rv + wg + 3;
    wd_seen = '0;
    st_req = 1'b1; st_addr = a; st_data = d; st_size = sz; rd_data = rdat;
    cyc = 0; done = 0; rd_cnt = 0; wr_cnt = 0; rd_k = 0; rd_wait = 0; saw_rd = 0; saw_wr = 0;
    while (!done && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
      rd_gnt = 1'b0; rd_valid = 1'b0; wr_gnt = 1'b0;
      if (drop) st_req = 1'b0;
      if (rd_wait) begin
        rd_k++;
        if (rd_k == rv) begin rd_valid = 1'b1; rd_wait = 1'b0; end
      end
      if (rd_req) begin
        saw_rd = 1'b1;
        check("rd_addr", rd_addr, exp_blk);
        if (rd_cnt == rg) begin
          rd_gnt = 1'b1;
          if (rv == 0) rd_valid = 1'b1;
          else begin rd_wait = 1'b1; rd_k = 0; end
        end
        rd_cnt++;
      end
      if (wr_req) begin
        saw_wr = 1'b1;
        wd_seen = wr_data;
        check("wr_addr", wr_addr, exp_blk);
        check("wr_data", wr_data, exp_wd);
        if (wr_cnt == wg) wr_gnt = 1'b1;
        wr_cnt++;
      end
      if (st_ack) begin
        done = 1'b1;
        check("st_misalign", 64'(st_misalign), 64'(mis));
        check("latency", 64'(cyc), 64'(exp_lat));
      end
    end
    check("ack_seen", 64'(done), 64'd1);
    rd_gnt = 1'b0; rd_valid = 1'b0; wr_gnt = 1'b0; st_req = 1'b0;
    check("rd_traffic", 64'(saw_rd), 64'(!mis && !hit));
    check("wr_traffic", 64'(saw_wr), 64'(!mis));
    @(posedge clock); #1;
    check("ack_pulse_idle", 64'({st_ack, st_misalign, busy}), 64'd0);
`ifdef RETIRE_STORE_FWD_EN
    if (!mis) begin m_fwd_valid = 1'b1; m_fwd_tag = a[31:3]; m_fwd_blk = exp_wd; end
`endif
  endtask

  initial begin
    reset = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0; wr_gnt = 1'b0;
    #1;
    check("reset_ctl", 64'({st_ack, st_misalign, rd_req, wr_req, busy}), 64'd0);
    check("reset_bus", rd_addr | wr_addr | wr_data, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // 1: byte store, immediate grants, data one cycle after read grant
    do_store(32'h1003, 32'hAB, 2'd0, 64'h1122334455667788, 0, 1, 0, 1'b0, wd);
    check("t1_wr_data", wd, 64'h11223344AB667788);
    // 2: half store into top lane
    do_store(32'h2006, 32'hBEEF, 2'd1, 64'h0, 0, 1, 0, 1'b0, wd);
    check("t2_wr_data", wd, 64'hBEEF000000000000);
    // 3: word store, write grant withheld for 3 cycles
    do_store(32'h3004, 32'hDEADBEEF, 2'd2, 64'h0123456789ABCDEF, 0, 1, 3, 1'b0, wd);
    check("t3_wr_data", wd, 64'hDEADBEEF89ABCDEF);
    // 4: misaligned half
    do_store(32'h2001, 32'h1234, 2'd1, 64'h0, 0, 0, 0, 1'b0, wd);
    // minimum latency path: grant and valid together
    do_store(32'h6010, 32'h55AA, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1'b0, wd);

    // 5: reset while waiting for read data
    st_req = 1'b1; st_addr = 32'h5008; st_data = 32'h77; st_size = 2'd0; rd_data = '0;
    @(posedge clock); #1;
    check("t5_rd_req", 64'(rd_req), 64'd1);
    rd_gnt = 1'b1;
    @(posedge clock); #1;
    rd_gnt = 1'b0;
    check("t5_in_wait", 64'({rd_req, wr_req, busy}), 64'b001);
    reset = 1'b1;
    #1;
    check("t5_reset_ctl", 64'({st_ack, st_misalign, rd_req, wr_req, busy}), 64'd0);
    check("t5_reset_bus", rd_addr | wr_addr | wr_data, 64'd0);
    st_req = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      check("t5_no_ack", 64'({st_ack, busy}), 64'd0);
    end
    reset = 1'b0;
    m_fwd_valid = 1'b0;
    do_store(32'h5008, 32'h77, 2'd0, 64'h8877665544332211, 1, 2, 1, 1'b0, wd);
    check("t5_after_reset", wd, 64'h8877665544332277);

    // 6: back-to-back bytes in one block
    do_store(32'h1000, 32'h01, 2'd0, 64'h0, 0, 1, 0, 1'b0, wd);
    do_store(32'h1001, 32'h02, 2'd0, 64'h0, 0, 1, 0, 1'b0, wd);
`ifdef RETIRE_STORE_FWD_EN
    check("t6_fwd_bytes", 64'(wd[15:0]), 64'h0201);
`endif

    // Random stores over four blocks, with st_req sometimes released early
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rdd;
      logic [63:0] rb;
      ra  = 32'h4000 + 32'($urandom_range(0, 3) * 8) + 32'($urandom_range(0, 7));
      rdd = $urandom;
      rb  = {$urandom, $urandom};
      do_store(ra, rdd, 2'($urandom_range(0, 3)), rb,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
